shiftreg_tap_n: RTL

//   Parametrised multi-stage delay line with a runtime-selectable tap. It

---
 rtl/shiftreg_tap_n.sv | 99 +++++++++
 1 files changed

// File: rtl/shiftreg_tap_n.sv
// WIDTH x DEPTH delay line with a runtime-selectable tap, shift enable, flush and fill tracking.
// Optional feature: define ROTATE_EN to add the rot input (circular rotate of the stages).
module shiftreg_tap_n #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int SELW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
`ifdef ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             sel_err,
    output logic [SELW-1:0]  fill
);

    localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [SELW-1:0]  fill_q;
    logic [SELW-1:0]  fill_d;
    logic [WIDTH-1:0] head;
    logic             grow;
    logic             hit;

    // Value entering stage 1 and whether this edge counts towards the fill level
    always_comb begin
        head = d;
        grow = 1'b1;
`ifdef ROTATE_EN
        if (rot) begin
            head = stage_q[DEPTH-1];
            grow = 1'b0;
        end
`endif
    end

    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = head;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (grow && (fill_q != DEPTH_S)) begin
                fill_d = fill_q + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Any nonzero select that matches no stage is out of range
    always_comb begin
        q       = '0;
        q_valid = 1'b0;
        hit     = 1'b0;
        if (sel == '0) begin
            q       = d;
            q_valid = 1'b1;
            hit     = 1'b1;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (sel == SELW'(k)) begin
                    q       = stage_q[k-1];
                    q_valid = (fill_q >= sel);
                    hit     = 1'b1;
                end
            end
        end
        sel_err = ~hit;
    end

    assign fill = fill_q;

endmodule
